// File: rtl/cache_miss_handler.sv
// Load-miss refill and write-through store controller for the 2-way data cache.
// Define CACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module cache_miss_handler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  input  logic                  cache_hit,
  output logic                  stall,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rd
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, FETCH, FILL} state_t;

  state_t                state;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  miss_pend;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic [DATA_WIDTH-1:0] fill_word;

  logic [ADDR_WIDTH-1:0] cpu_addr_al;
  logic                  unused_addr_lo;
  logic                  free, wb_done, st_req, st_acc, ld_hit, ld_miss;

  assign cpu_addr_al    = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr_lo = ^cpu_addr[1:0];

  // CPU requests are only looked at while no load miss is in flight; a
  // background drain (WRITE without a pending miss) still serves the CPU.
  always_comb begin
    free    = (state == IDLE) || ((state == WRITE) && !miss_pend);
    wb_done = (state == WRITE) && mem_ready;
    st_req  = free && cpu_we;
    st_acc  = st_req && (!wb_valid || wb_done);
    ld_hit  = free && cpu_re && !cpu_we && cache_hit;
    ld_miss = free && cpu_re && !cpu_we && !cache_hit;
  end

  always_comb begin
    stall     = miss_pend || ld_miss || (st_req && !st_acc);
    mem_req   = (state == WRITE) || (state == FETCH);
    mem_we    = (state == WRITE);
    mem_addr  = '0;
    mem_wd    = '0;
    fill_we   = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    if (state == WRITE) begin
      mem_addr = wb_addr;
      mem_wd   = wb_data;
    end else if (state == FETCH) begin
      mem_addr = miss_addr;
    end
    if (state == FILL) begin
      fill_we   = 1'b1;
      fill_addr = miss_addr;
      fill_data = fill_word;
    end else if (st_acc && cache_hit) begin
      fill_we   = 1'b1;
      fill_addr = cpu_addr_al;
      fill_data = cpu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      miss_pend <= 1'b0;
      miss_addr <= '0;
      fill_word <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (st_acc) begin
            wb_valid <= 1'b1;
            wb_addr  <= cpu_addr_al;
            wb_data  <= cpu_wd;
            state    <= WRITE;
          end else if (ld_miss) begin
            miss_pend <= 1'b1;
            miss_addr <= cpu_addr_al;
            state     <= wb_valid ? WRITE : FETCH;
          end else if (wb_valid) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (ld_miss) begin
            miss_pend <= 1'b1;
            miss_addr <= cpu_addr_al;
          end
          if (mem_ready) begin
            // A store landing on the completion cycle refills the buffer and
            // starts the next drain straight away.
            if (st_acc) begin
              wb_addr <= cpu_addr_al;
              wb_data <= cpu_wd;
            end else begin
              wb_valid <= 1'b0;
              state    <= (miss_pend || ld_miss) ? FETCH : IDLE;
            end
          end
        end
        FETCH: begin
          if (mem_ready) begin
            fill_word <= mem_rd;
            state     <= FILL;
          end
        end
        FILL: begin
          miss_pend <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ld_hit && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (ld_miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_handler.sv
// Randomized bench for cache_miss_handler against a word-level memory model.
// Define CACHE_PERF_CNT_EN to also check the performance counters.
module tb_cache_miss_handler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_re = 1'b0, cpu_we = 1'b0, cache_hit = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wd = '0;
  logic        stall, fill_we, mem_req, mem_we;
  logic [31:0] fill_addr, fill_data, mem_addr, mem_wd;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rd = '0;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_miss_handler #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cache_hit(cache_hit), .stall(stall), .fill_we(fill_we),
    .fill_addr(fill_addr), .fill_data(fill_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_ready(mem_ready), .mem_rd(mem_rd)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mem: what main memory holds; arch: what program order says it must hold
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] arch [logic [31:0]];
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t wq[$];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] arch_val(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : init_val(a);
  endfunction

  int          lat_fix = -1;
  bit          busy = 0;
  int          cnt = 0;
  logic [31:0] sa, swd;
  logic        swe;
  int          exp_hit = 0, exp_miss = 0;
  logic [31:0] last_fill = '0;

  // Memory side: picks a latency per request and checks the handshake is held.
  task automatic mem_step();
    if (mem_req) begin
      if (!busy) begin
        busy = 1;
        cnt  = (lat_fix > 0) ? lat_fix - 1 : int'($urandom_range(0, 3));
        sa = mem_addr; swe = mem_we; swd = mem_wd;
        chk("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      end else begin
        chk("hs_addr", mem_addr, sa);
        chk("hs_we", {31'b0, mem_we}, {31'b0, swe});
        if (swe) chk("hs_wd", mem_wd, swd);
      end
      if (cnt == 0) begin
        mem_ready = 1'b1;
        busy = 0;
        if (swe) begin
          if (wq.size() == 0) chk("wr_unexpected", 32'(wq.size()), 32'd1);
          else begin
            wr_t e = wq.pop_front();
            chk("wr_addr", sa, e.a);
            chk("wr_data", swd, e.d);
          end
          mem[sa] = swd;
          mem_rd = $urandom;
        end else begin
          mem_rd = mem_val(sa);
        end
      end else begin
        mem_ready = 1'b0;
        cnt--;
        mem_rd = $urandom;
      end
    end else begin
      busy = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rd = $urandom;
    end
  endtask

  task automatic cyc(input logic re, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic hit);
    @(negedge clk);
    cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wd = wd; cache_hit = hit;
    mem_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, $urandom, $urandom, 1'($urandom));
      chk("idle_stall", {31'b0, stall}, 32'h0);
      chk("idle_fill", {31'b0, fill_we}, 32'h0);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic hit,
                          output int stalls);
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(0, 1, a, d, hit);
      if (!stall) begin
        chk("st_fill_we", {31'b0, fill_we}, {31'b0, hit});
        if (hit) begin
          chk("st_fill_addr", fill_addr, al);
          chk("st_fill_data", fill_data, d);
        end
        arch[al] = d;
        wq.push_back({al, d});
        return;
      end
      chk("st_wait_fill", {31'b0, fill_we}, 32'h0);
      stalls++;
    end
    chk("st_timeout", 32'(stalls), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic hit, output int stalls);
    logic [31:0] al;
    int fills;
    al = {a[31:2], 2'b00};
    stalls = 0;
    fills = 0;
    if (hit) begin
      cyc(1, 0, a, $urandom, 1);
      chk("ld_hit_stall", {31'b0, stall}, 32'h0);
      chk("ld_hit_fill", {31'b0, fill_we}, 32'h0);
      exp_hit++;
      return;
    end
    exp_miss++;
    for (int i = 0; i < 60; i++) begin
      // once the fill has happened the replayed lookup hits
      cyc(1, 0, a, $urandom, fills != 0);
      if (!stall) begin
        chk("ld_fills", 32'(fills), 32'd1);
        exp_hit++;
        return;
      end
      stalls++;
      if (fill_we) begin
        fills++;
        last_fill = fill_data;
        chk("ld_fill_addr", fill_addr, al);
        chk("ld_fill_data", fill_data, arch_val(al));
      end
    end
    chk("ld_timeout", 32'(stalls), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cpu_re = 0; cpu_we = 0; mem_ready = 0;
    @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_fill_we", {31'b0, fill_we}, 32'h0);
`ifdef CACHE_PERF_CNT_EN
    chk("rst_hit_cnt", hit_count, 32'h0);
    chk("rst_miss_cnt", miss_count, 32'h0);
`endif
    rst = 1'b0;
    busy = 0;
    wq.delete();
    arch = mem;
    exp_hit = 0;
    exp_miss = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (wq.size() != 0 || mem_req); i++) idle(1);
    chk("drain_empty", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    int s;
    do_reset();
    idle(5);

    // load miss with 3-cycle memory
    mem[32'h100] = 32'hDEADBEEF;
    arch[32'h100] = 32'hDEADBEEF;
    lat_fix = 3;
    do_load(32'h100, 0, s);
    chk("miss_stall_cycles", 32'(s), 32'd5);
    chk("miss_fill_data", last_fill, 32'hDEADBEEF);

    // store hit, then drain
    lat_fix = 2;
    do_store(32'h200, 32'h12345678, 1, s);
    chk("st_hit_stalls", 32'(s), 32'd0);
    cyc(0, 0, 32'h0, 32'h0, 0);
    chk("drain_req", {31'b0, mem_req}, 32'h1);
    chk("drain_we", {31'b0, mem_we}, 32'h1);
    chk("drain_addr", mem_addr, 32'h200);
    chk("drain_wd", mem_wd, 32'h12345678);
    drain();

    // read-after-write to the same word must see the buffered store
    lat_fix = 4;
    do_store(32'h300, 32'hA5A5A5A5, 0, s);
    do_load(32'h300, 0, s);
    chk("raw_fill_data", last_fill, 32'hA5A5A5A5);
    drain();

    // second store waits for the first to drain
    lat_fix = 3;
    do_store(32'h400, 32'h11111111, 0, s);
    do_store(32'h404, 32'h22222222, 0, s);
    chk("st_busy_stalls", 32'(s), 32'd2);
    drain();

    // randomized mix on a few words, unaligned byte offsets included
    lat_fix = -1;
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a  = 32'h1000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if (op < 4)      do_store(a, $urandom, 1'($urandom), s);
      else if (op < 8) do_load(a, 1'($urandom), s);
      else             idle(int'($urandom_range(1, 3)));
    end
    drain();
    idle(1);
`ifdef CACHE_PERF_CNT_EN
    chk("hit_count", hit_count, 32'(exp_hit));
    chk("miss_count", miss_count, 32'(exp_miss));
`endif

    // reset in the middle of a fetch
    lat_fix = 10;
    cyc(1, 0, 32'h500, 32'h0, 0);
    chk("fetch_detect_stall", {31'b0, stall}, 32'h1);
    cyc(1, 0, 32'h500, 32'h0, 0);
    chk("fetch_req", {31'b0, mem_req}, 32'h1);
    do_reset();
    lat_fix = -1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
- Miss/refill controller between the 2-way set-associative data cache and main data memory.
- On a load miss it stalls the CPU, fetches the word from memory over a req/ready handshake, and writes it into the cache through the fill port.
- Stores are write-through, no-write-allocate, via a one-entry write buffer.
- Sits directly downstream of the cache lookup and consumes its hit signal.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_re  in  1  load request this cycle.
- cpu_we  in  1  store request this cycle.
- cpu_addr  in  ADDR_WIDTH  byte address of the access.
- cpu_wd  in  DATA_WIDTH  store data.
- cache_hit  in  1  hit result from the cache lookup for cpu_addr.
- stall  out  1  freezes the CPU pipeline.
- fill_we  out  1  cache write strobe.
- fill_addr  out  ADDR_WIDTH  cache write address (word-aligned).
- fill_data  out  DATA_WIDTH  cache write data.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = memory write, 0 = memory read.
- mem_addr  out  ADDR_WIDTH  memory address (word-aligned, low 2 bits 0).
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_rd  in  DATA_WIDTH  memory read data, valid when mem_ready=1.

Behaviour:
- Reset:
  - rst sampled high → state IDLE, write buffer invalid, miss address/data registers cleared.
  - All outputs 0 the cycle after reset.
  - In-flight memory transaction is abandoned; memory must tolerate mem_req dropping.
- FSM states:
  - IDLE: no transaction outstanding.
  - WRITE: draining the write buffer to memory.
  - FETCH: read outstanding.
  - FILL: writing fetched data into the cache.
- Handshake:
  - mem_req/mem_we/mem_addr/mem_wd are stable from assertion until the cycle mem_ready=1 is sampled.
  - Transaction completes in that cycle.
  - mem_ready while mem_req=0 is ignored.
- Write buffer: one entry (wb_valid, wb_addr, wb_data).
- Store handling (cpu_we=1):
  - Accepted in IDLE when wb_valid=0 or the buffer completes this cycle. Captured at the clock edge; stall=0.
  - If cache_hit=1 in the acceptance cycle: fill_we=1, fill_addr=aligned cpu_addr, fill_data=cpu_wd, combinationally (write-through update).
  - If not accepted: stall=1 until accepted.
- IDLE with wb_valid=1 and no load miss → WRITE.
  - Drives mem_req=1, mem_we=1, mem_addr=wb_addr, mem_wd=wb_data.
  - On mem_ready: wb_valid←0, → IDLE.
- Load miss (cpu_re=1, cache_hit=0) in IDLE:
  - stall=1 combinationally in the same cycle.
  - Miss address latched.
  - Next state is WRITE if wb_valid=1 (drain first; preserves ordering and read-after-write to same address), else FETCH.
  - After WRITE completes with a pending miss → FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=miss address.
  - On mem_ready: mem_rd captured, → FILL.
- FILL (exactly 1 cycle):
  - fill_we=1, fill_addr=miss address, fill_data=captured word, stall=1.
  - → IDLE. The CPU's replayed lookup hits next cycle.
- Load-miss latency: stall high for (drain cycles, if any) + (memory cycles to mem_ready) + 1 FILL cycle.
- stall: high in WRITE/FETCH/FILL when a load miss is pending. A background drain with no pending miss does not stall.
- Load hit: no action, stall=0.
- cpu_re and cpu_we both high is illegal; cpu_we takes priority and the load is ignored.
- CPU requests arriving while stalled are ignored; the CPU holds them stable.
- Address alignment: low 2 bits of all outgoing addresses forced to 0.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_count and miss_count (32 bits each).
  - Increment once per accepted load hit and once per load miss (at miss detection).
  - Saturate at all-ones; cleared by rst.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset, then idle 5 cycles → stall=0, mem_req=0, fill_we=0.
- Load 0x100 with cache_hit=0, memory returns 0xDEADBEEF with mem_ready after 3 cycles → stall high 5 cycles (detect+3 wait+FILL). FILL cycle shows fill_we=1, fill_addr=0x100, fill_data=0xDEADBEEF.
- Store 0x200←0x12345678, cache_hit=1 → same-cycle fill_we=1 with those values, stall=0. Next cycle mem_req=1, mem_we=1, mem_addr=0x200 until mem_ready.
- Store 0x300←0xA5A5A5A5 (memory not ready), then load miss 0x300 → WRITE completes before the FETCH request. Fetch mem_addr=0x300; returned 0xA5A5A5A5 written via fill.
- Second store while buffer busy → stall=1 until the drain's mem_ready, then accepted.
- rst asserted during FETCH → next cycle mem_req=0, stall=0, state IDLE. With CACHE_PERF_CNT_EN: counters read 0.
